// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit.
//   state_t     : FSM state encodings (IDLE, REQ, DRAIN)
//   size_t      : decoded access size (byte, half, word)
//   SEL_BYTE / SEL_HALF : op_sel encodings for byte and half accesses;
//                 a word access is the all-ones mask, whose width depends on
//                 the data width and so is built inside the modules.
//   lane_count(): number of byte lanes on a data bus of a given width.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    localparam int SEL_BYTE = 1;
    localparam int SEL_HALF = 3;

    function automatic int lane_count(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// mem_lane_align: combinational byte-lane steering.
//   Store mode (load_mode=0): data_out = data_in shifted up to the lane at
//   'offset'; lane_we = byte-enable mask for the access size at that offset.
//   Load mode  (load_mode=1): data_out = lane(s) at 'offset' shifted down to
//   bit 0, upper bits filled with the sign bit if sign_ext, else zero.
// Ports:
//   load_mode  in   select load extraction (1) or store steering (0)
//   size       in   access size
//   offset     in   byte offset inside the bus word
//   sign_ext   in   sign-extend the extracted load value
//   data_in    in   store data (low-aligned) or raw bus read data
//   data_out   out  steered / extracted data
//   lane_we    out  byte-lane mask for this size/offset
module mem_lane_align
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OFS_W      = 2
) (
    input  logic                    load_mode,
    input  size_t                   size,
    input  logic [OFS_W-1:0]        offset,
    input  logic                    sign_ext,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic [DATA_WIDTH/8-1:0] lane_we
);

    localparam int LANES    = DATA_WIDTH / 8;
    localparam int HALF_MSB = (DATA_WIDTH >= 16) ? 15 : DATA_WIDTH - 1;

    logic [LANES-1:0]      size_mask;
    logic [DATA_WIDTH-1:0] shifted_up;
    logic [DATA_WIDTH-1:0] shifted_down;
    logic [DATA_WIDTH-1:0] extended;
    logic                  sign_bit;

    always_comb begin
        size_mask = '1;
        case (size)
            SZ_BYTE: size_mask = LANES'(SEL_BYTE);
            SZ_HALF: size_mask = LANES'(SEL_HALF);
            default: size_mask = '1;
        endcase
    end

    assign shifted_up   = data_in << {offset, 3'b000};
    assign shifted_down = data_in >> {offset, 3'b000};
    assign lane_we      = size_mask << offset;

    // Sign bit is the top bit of the extracted field, not of the bus word.
    always_comb begin
        sign_bit = shifted_down[DATA_WIDTH-1];
        case (size)
            SZ_BYTE: sign_bit = shifted_down[7];
            SZ_HALF: sign_bit = shifted_down[HALF_MSB];
            default: sign_bit = shifted_down[DATA_WIDTH-1];
        endcase
    end

    // After shifting down, the kept field occupies exactly the lanes set in
    // size_mask; every other lane becomes the fill byte.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_ext
            assign extended[gi*8 +: 8] = size_mask[gi] ? shifted_down[gi*8 +: 8]
                                                       : {8{sign_ext & sign_bit}};
        end
    endgenerate

    assign data_out = load_mode ? extended : shifted_up;

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle load/store unit between the EX/MEM register
// and a variable-latency data RAM (req/ack handshake).
// Optional feature macro: MEM_ALIGN_EXC_EN -- when defined, a misaligned
// request pulses addr_err one cycle after the request; when undefined,
// misaligned requests are silently dropped and addr_err is tied 0.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   op_valid/op_read/op_write access request (write wins if both set)
//   op_sign_ext, op_sel       load sign extension, size mask
//   op_addr, op_wdata         byte address, low-aligned store data
//   flush                     abandon the in-flight access
//   bus_req/bus_we/bus_addr/bus_wdata   RAM request side (held until ack)
//   bus_ack/bus_rdata         RAM completion and read data
//   stall_req                 freeze earlier pipeline stages
//   done/load_data            completion pulse and extended load result
//   addr_err, bus_err         misalignment and timeout pulses
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    op_valid,
    input  logic                    op_read,
    input  logic                    op_write,
    input  logic                    op_sign_ext,
    input  logic [DATA_WIDTH/8-1:0] op_sel,
    input  logic [ADDR_WIDTH-1:0]   op_addr,
    input  logic [DATA_WIDTH-1:0]   op_wdata,
    input  logic                    flush,
    output logic                    bus_req,
    output logic [DATA_WIDTH/8-1:0] bus_we,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic [DATA_WIDTH-1:0]   bus_wdata,
    input  logic                    bus_ack,
    input  logic [DATA_WIDTH-1:0]   bus_rdata,
    output logic                    stall_req,
    output logic                    done,
    output logic [DATA_WIDTH-1:0]   load_data,
    output logic                    addr_err,
    output logic                    bus_err
);

    localparam int LANES = lane_count(DATA_WIDTH);
    localparam int OFS_W = $clog2(LANES);

    state_t                  state_reg;
    logic                    bus_req_reg;
    logic [LANES-1:0]        we_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    size_t                   size_reg;
    logic [OFS_W-1:0]        ofs_reg;
    logic                    sign_reg;
    logic [31:0]             to_cnt_reg;
    logic                    done_reg;
    logic [DATA_WIDTH-1:0]   load_data_reg;
    logic                    bus_err_reg;

    logic [OFS_W-1:0]        op_ofs;
    size_t                   sel_size;
    logic                    sel_ok;
    logic                    op_active;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   store_lanes;
    logic [LANES-1:0]        store_we;
    logic [DATA_WIDTH-1:0]   load_ext;
    logic [LANES-1:0]        load_we_unused;

    assign op_ofs = op_addr[OFS_W-1:0];

    // Size decode and alignment: any mask other than byte/half/word is
    // treated as misaligned so it can never reach the bus.
    always_comb begin
        sel_size = SZ_BYTE;
        sel_ok   = 1'b0;
        if (op_sel == {LANES{1'b1}}) begin
            sel_size = SZ_WORD;
            sel_ok   = (op_ofs == '0);
        end else if (op_sel == LANES'(SEL_HALF)) begin
            sel_size = SZ_HALF;
            sel_ok   = ~op_ofs[0];
        end else if (op_sel == LANES'(SEL_BYTE)) begin
            sel_size = SZ_BYTE;
            sel_ok   = 1'b1;
        end
    end

    assign op_active = (state_reg == ST_IDLE) && !rst && op_valid
                       && (op_read || op_write) && !flush;
    assign accept    = op_active && sel_ok;

    // Store steering works on the live op_* inputs so the lanes can be
    // latched in the accept cycle.
    mem_lane_align #(
        .DATA_WIDTH (DATA_WIDTH),
        .OFS_W      (OFS_W)
    ) u_store_align (
        .load_mode (1'b0),
        .size      (sel_size),
        .offset    (op_ofs),
        .sign_ext  (1'b0),
        .data_in   (op_wdata),
        .data_out  (store_lanes),
        .lane_we   (store_we)
    );

    // Load extraction works on the latched size/offset and the bus data.
    mem_lane_align #(
        .DATA_WIDTH (DATA_WIDTH),
        .OFS_W      (OFS_W)
    ) u_load_align (
        .load_mode (1'b1),
        .size      (size_reg),
        .offset    (ofs_reg),
        .sign_ext  (sign_reg),
        .data_in   (bus_rdata),
        .data_out  (load_ext),
        .lane_we   (load_we_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            bus_req_reg   <= 1'b0;
            we_reg        <= '0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            size_reg      <= SZ_BYTE;
            ofs_reg       <= '0;
            sign_reg      <= 1'b0;
            to_cnt_reg    <= '0;
            done_reg      <= 1'b0;
            load_data_reg <= '0;
            bus_err_reg   <= 1'b0;
        end else begin
            done_reg    <= 1'b0;
            bus_err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    to_cnt_reg <= '0;
                    if (accept) begin
                        state_reg   <= ST_REQ;
                        bus_req_reg <= 1'b1;
                        addr_reg    <= {op_addr[ADDR_WIDTH-1:OFS_W], {OFS_W{1'b0}}};
                        we_reg      <= op_write ? store_we : '0;
                        wdata_reg   <= op_write ? store_lanes : '0;
                        size_reg    <= sel_size;
                        ofs_reg     <= op_ofs;
                        sign_reg    <= op_sign_ext;
                    end
                end
                ST_REQ: begin
                    if (bus_ack) begin
                        // A flush in the ack cycle discards the result.
                        state_reg   <= ST_IDLE;
                        bus_req_reg <= 1'b0;
                        to_cnt_reg  <= '0;
                        if (!flush) begin
                            done_reg      <= 1'b1;
                            load_data_reg <= (|we_reg) ? '0 : load_ext;
                        end
                    end else if (flush) begin
                        // Keep requesting: the RAM has the access and must
                        // be allowed to finish it.
                        state_reg  <= ST_DRAIN;
                        to_cnt_reg <= '0;
                    end else if ((TIMEOUT_CYCLES != 0)
                                 && (to_cnt_reg == 32'(TIMEOUT_CYCLES - 1))) begin
                        state_reg   <= ST_IDLE;
                        bus_req_reg <= 1'b0;
                        bus_err_reg <= 1'b1;
                        to_cnt_reg  <= '0;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 32'd1;
                    end
                end
                ST_DRAIN: begin
                    if (bus_ack) begin
                        state_reg   <= ST_IDLE;
                        bus_req_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    bus_req_reg <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_ALIGN_EXC_EN
    logic addr_err_reg;
    logic misaligned;

    assign misaligned = op_active && !sel_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_err_reg <= 1'b0;
        end else begin
            addr_err_reg <= misaligned;
        end
    end

    assign addr_err = addr_err_reg;
`else
    assign addr_err = 1'b0;
`endif

    assign bus_req   = bus_req_reg;
    assign bus_we    = we_reg;
    assign bus_addr  = addr_reg;
    assign bus_wdata = wdata_reg;
    assign stall_req = accept || (state_reg == ST_REQ);
    assign done      = done_reg;
    assign load_data = load_data_reg;
    assign bus_err   = bus_err_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit (DATA_WIDTH=32, TIMEOUT_CYCLES=4).
// The stimulus process pushes expected responses and expected bus requests;
// a monitor checks done/addr_err/bus_err pulses and a RAM responder checks
// each bus request and answers it with a programmed delay.
module tb_mem_access_unit;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int LN = DW / 8;

    logic          clk;
    logic          rst;
    logic          op_valid, op_read, op_write, op_sign_ext;
    logic [LN-1:0] op_sel;
    logic [AW-1:0] op_addr;
    logic [DW-1:0] op_wdata;
    logic          flush;
    logic          bus_req;
    logic [LN-1:0] bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_ack;
    logic [DW-1:0] bus_rdata;
    logic          stall_req, done, addr_err, bus_err;
    logic [DW-1:0] load_data;

    mem_access_unit #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .op_valid    (op_valid),
        .op_read     (op_read),
        .op_write    (op_write),
        .op_sign_ext (op_sign_ext),
        .op_sel      (op_sel),
        .op_addr     (op_addr),
        .op_wdata    (op_wdata),
        .flush       (flush),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata),
        .stall_req   (stall_req),
        .done        (done),
        .load_data   (load_data),
        .addr_err    (addr_err),
        .bus_err     (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 = done, 1 = addr_err, 2 = bus_err
    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] data;
        logic        chk_data;
        logic [7:0]  tag;
    } resp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [7:0]  delay;
        logic        ack_en;
        logic        chk_stall;
        logic [7:0]  req_cycles;
        logic [7:0]  tag;
    } bus_t;

    resp_t sbq[$];
    bus_t  bq[$];
    int    total = 0;
    int    bad   = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_resp(input logic [1:0] kind, input logic [31:0] data,
                             input logic chk_data, input logic [7:0] tag);
        resp_t r;
        r.kind = kind; r.data = data; r.chk_data = chk_data; r.tag = tag;
        sbq.push_back(r);
    endtask

    task automatic push_bus(input logic [31:0] addr, input logic [3:0] we,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input logic [7:0] delay, input logic ack_en,
                            input logic chk_stall, input logic [7:0] req_cycles,
                            input logic [7:0] tag);
        bus_t b;
        b.addr = addr; b.we = we; b.wdata = wdata; b.rdata = rdata;
        b.delay = delay; b.ack_en = ack_en; b.chk_stall = chk_stall;
        b.req_cycles = req_cycles; b.tag = tag;
        bq.push_back(b);
    endtask

    // Drives one request for exactly one cycle; checks stall_req in that cycle.
    task automatic issue(input logic rd, input logic wr, input logic sx,
                         input logic [3:0] sel, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic exp_stall,
                         input logic [7:0] tag);
        op_valid = 1'b1; op_read = rd; op_write = wr; op_sign_ext = sx;
        op_sel = sel; op_addr = addr; op_wdata = wdata;
        @(negedge clk);
        chk($sformatf("t%0d_accept_stall", tag), 128'(stall_req), 128'(exp_stall));
        $display("issue t%0d rd=%0b wr=%0b sx=%0b sel=%b addr=%h wdata=%h",
                 tag, rd, wr, sx, sel, addr, wdata);
        step();
        op_valid = 1'b0; op_read = 1'b0; op_write = 1'b0; op_sign_ext = 1'b0;
        op_sel = '0; op_addr = '0; op_wdata = '0;
    endtask

    task automatic wait_quiet(input logic [7:0] tag);
        int n;
        n = 0;
        while ((bus_req || stall_req) && n < 60) begin
            step();
            n++;
        end
        if (n >= 60) begin
            total++;
            bad++;
            $display("FAIL t%0d_quiet_timeout: got=busy expected=idle within 60 cycles", tag);
        end
        step();
        step();
    endtask

    // Monitor: every completion/error pulse must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (done || addr_err || bus_err) begin
                logic [1:0] k;
                k = done ? 2'd0 : (addr_err ? 2'd1 : 2'd2);
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: got kind=%0d expected=none", k);
                end else begin
                    resp_t r;
                    r = sbq.pop_front();
                    chk($sformatf("t%0d_kind", r.tag), 128'(k), 128'(r.kind));
                    if (r.chk_data)
                        chk($sformatf("t%0d_load_data", r.tag), 128'(load_data), 128'(r.data));
                    if (k == 2'd0)
                        chk($sformatf("t%0d_done_stall", r.tag), 128'(stall_req), 128'(0));
                    if (k == 2'd2)
                        chk($sformatf("t%0d_err_req_drop", r.tag), 128'(bus_req), 128'(0));
                    $display("event t%0d kind=%0d load_data=%h", r.tag, k, load_data);
                end
            end
        end
    end

    // RAM responder: checks the request fields and acks after 'delay' extra cycles.
    initial begin
        bus_ack   = 1'b0;
        bus_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus_req) begin
                if (bq.size() == 0) begin
                    int w;
                    total++;
                    bad++;
                    $display("FAIL bus_unexpected: got bus_req addr=%h expected=no request", bus_addr);
                    w = 0;
                    while (bus_req && w < 100) begin
                        @(negedge clk);
                        w++;
                    end
                end else begin
                    bus_t e;
                    e = bq.pop_front();
                    chk($sformatf("t%0d_bus_addr", e.tag), 128'(bus_addr), 128'(e.addr));
                    chk($sformatf("t%0d_bus_we", e.tag), 128'(bus_we), 128'(e.we));
                    chk($sformatf("t%0d_bus_wdata", e.tag), 128'(bus_wdata), 128'(e.wdata));
                    if (e.ack_en) begin
                        for (int i = 0; i < int'(e.delay); i++) begin
                            if (e.chk_stall)
                                chk($sformatf("t%0d_req_stall", e.tag), 128'(stall_req), 128'(1));
                            @(negedge clk);
                            chk($sformatf("t%0d_req_hold", e.tag), {bus_req, bus_addr}, {1'b1, e.addr});
                        end
                        if (e.chk_stall)
                            chk($sformatf("t%0d_req_stall", e.tag), 128'(stall_req), 128'(1));
                        bus_ack   = 1'b1;
                        bus_rdata = e.rdata;
                        @(negedge clk);
                        bus_ack   = 1'b0;
                        bus_rdata = ~e.rdata;
                        chk($sformatf("t%0d_req_drop", e.tag), 128'(bus_req), 128'(0));
                    end else begin
                        int n;
                        n = 0;
                        while (bus_req && n < 100) begin
                            n++;
                            @(negedge clk);
                        end
                        if (e.req_cycles != 0)
                            chk($sformatf("t%0d_req_cycles", e.tag), 128'(n), 128'(e.req_cycles));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=still running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_all_zero(input string name);
        chk(name, {bus_req, bus_we, bus_addr, bus_wdata, stall_req, done, addr_err, bus_err},
            128'(0));
        chk({name, "_load"}, 128'(load_data), 128'(0));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        op_valid = 1'b0; op_read = 1'b0; op_write = 1'b0; op_sign_ext = 1'b0;
        op_sel = '0; op_addr = '0; op_wdata = '0;
        repeat (3) step();
        @(negedge clk);
        chk_all_zero("reset_outputs");
        step();
        rst = 1'b0;
        step();

        // t1: byte store at offset 3, ack in the third REQ cycle; a stray op
        // driven during REQ must be ignored.
        push_bus(32'h1000, 4'b1000, 32'hA500_0000, 32'h5555_5555, 8'd2, 1'b1, 1'b1, 8'd0, 8'd1);
        push_resp(2'd0, 32'h0, 1'b0, 8'd1);
        issue(1'b0, 1'b1, 1'b0, 4'b0001, 32'h0000_1003, 32'h0000_00A5, 1'b1, 8'd1);
        op_valid = 1'b1; op_read = 1'b1; op_sel = 4'b1111; op_addr = 32'h7770;
        step();
        op_valid = 1'b0; op_read = 1'b0; op_sel = '0; op_addr = '0;
        wait_quiet(8'd1);

        // t2/t3: half loads at 0x2002, signed then unsigned.
        push_bus(32'h2000, 4'b0000, 32'h0, 32'h8001_1234, 8'd0, 1'b1, 1'b1, 8'd0, 8'd2);
        push_resp(2'd0, 32'hFFFF_8001, 1'b1, 8'd2);
        issue(1'b1, 1'b0, 1'b1, 4'b0011, 32'h0000_2002, 32'h0, 1'b1, 8'd2);
        wait_quiet(8'd2);
        push_bus(32'h2000, 4'b0000, 32'h0, 32'h8001_1234, 8'd1, 1'b1, 1'b1, 8'd0, 8'd3);
        push_resp(2'd0, 32'h0000_8001, 1'b1, 8'd3);
        issue(1'b1, 1'b0, 1'b0, 4'b0011, 32'h0000_2002, 32'h0, 1'b1, 8'd3);
        wait_quiet(8'd3);

        // t4..t6: signed byte, unsigned byte, word load.
        push_bus(32'h1000, 4'b0000, 32'h0, 32'h1234_80FF, 8'd0, 1'b1, 1'b1, 8'd0, 8'd4);
        push_resp(2'd0, 32'hFFFF_FF80, 1'b1, 8'd4);
        issue(1'b1, 1'b0, 1'b1, 4'b0001, 32'h0000_1001, 32'h0, 1'b1, 8'd4);
        wait_quiet(8'd4);
        push_bus(32'h1000, 4'b0000, 32'h0, 32'h1234_5678, 8'd1, 1'b1, 1'b1, 8'd0, 8'd5);
        push_resp(2'd0, 32'h0000_0034, 1'b1, 8'd5);
        issue(1'b1, 1'b0, 1'b0, 4'b0001, 32'h0000_1002, 32'h0, 1'b1, 8'd5);
        wait_quiet(8'd5);
        push_bus(32'h4000, 4'b0000, 32'h0, 32'hDEAD_BEEF, 8'd0, 1'b1, 1'b1, 8'd0, 8'd6);
        push_resp(2'd0, 32'hDEAD_BEEF, 1'b1, 8'd6);
        issue(1'b1, 1'b0, 1'b1, 4'b1111, 32'h0000_4000, 32'h0, 1'b1, 8'd6);
        wait_quiet(8'd6);

        // t7/t8: half store to upper lanes, word store; write wins over read.
        push_bus(32'h2000, 4'b1100, 32'hBEEF_0000, 32'h0, 8'd1, 1'b1, 1'b1, 8'd0, 8'd7);
        push_resp(2'd0, 32'h0, 1'b0, 8'd7);
        issue(1'b0, 1'b1, 1'b0, 4'b0011, 32'h0000_2002, 32'h1234_BEEF, 1'b1, 8'd7);
        wait_quiet(8'd7);
        push_bus(32'h3000, 4'b1111, 32'h1122_3344, 32'h0, 8'd0, 1'b1, 1'b1, 8'd0, 8'd8);
        push_resp(2'd0, 32'h0, 1'b0, 8'd8);
        issue(1'b1, 1'b1, 1'b0, 4'b1111, 32'h0000_3000, 32'h1122_3344, 1'b1, 8'd8);
        wait_quiet(8'd8);

        // t9..t11: misaligned word, misaligned half, illegal size mask.
        for (int m = 0; m < 3; m++) begin
            logic [3:0]  msel;
            logic [31:0] maddr;
            logic [7:0]  mtag;
            msel  = (m == 0) ? 4'b1111 : ((m == 1) ? 4'b0011 : 4'b0101);
            maddr = (m == 0) ? 32'h3001 : ((m == 1) ? 32'h2001 : 32'h4000);
            mtag  = 8'(9 + m);
`ifdef MEM_ALIGN_EXC_EN
            push_resp(2'd1, 32'h0, 1'b0, mtag);
`endif
            issue(1'b1, (m == 2), 1'b0, msel, maddr, 32'h0, 1'b0, mtag);
            @(negedge clk);
            chk($sformatf("t%0d_misalign_no_req", mtag), {bus_req, stall_req}, 128'(0));
            step();
            step();
        end

        // t12: flush in the first REQ cycle, ack two cycles later -> DRAIN,
        // no done; t13 is accepted in the cycle after the ack.
        push_bus(32'h5000, 4'b0000, 32'h0, 32'hCAFE_F00D, 8'd2, 1'b1, 1'b0, 8'd0, 8'd12);
        issue(1'b1, 1'b0, 1'b0, 4'b1111, 32'h0000_5000, 32'h0, 1'b1, 8'd12);
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("t12_drain_req_nostall", {bus_req, stall_req}, {1'b1, 1'b0});
        step();
        step();
        push_bus(32'h4000, 4'b0000, 32'h0, 32'h0000_7F7F, 8'd0, 1'b1, 1'b1, 8'd0, 8'd13);
        push_resp(2'd0, 32'h0000_7F7F, 1'b1, 8'd13);
        issue(1'b1, 1'b0, 1'b1, 4'b0011, 32'h0000_4000, 32'h0, 1'b1, 8'd13);
        wait_quiet(8'd13);

        // t14: no ack -> bus_err after exactly 4 REQ cycles.
        push_bus(32'h5000, 4'b0000, 32'h0, 32'h0, 8'd0, 1'b0, 1'b0, 8'd4, 8'd14);
        push_resp(2'd2, 32'h0, 1'b0, 8'd14);
        issue(1'b1, 1'b0, 1'b0, 4'b1111, 32'h0000_5000, 32'h0, 1'b1, 8'd14);
        wait_quiet(8'd14);

        // t15: reset in the middle of REQ.
        push_bus(32'h5004, 4'b0000, 32'h0, 32'h0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd15);
        issue(1'b1, 1'b0, 1'b0, 4'b1111, 32'h0000_5004, 32'h0, 1'b1, 8'd15);
        step();
        rst = 1'b1;
        step();
        chk_all_zero("t15_after_rst");
        rst = 1'b0;
        step();

        // t16/t17: load then store straight after the reset.
        push_bus(32'h6000, 4'b0000, 32'h0, 32'h0BAD_F00D, 8'd1, 1'b1, 1'b1, 8'd0, 8'd16);
        push_resp(2'd0, 32'h0BAD_F00D, 1'b1, 8'd16);
        issue(1'b1, 1'b0, 1'b0, 4'b1111, 32'h0000_6000, 32'h0, 1'b1, 8'd16);
        wait_quiet(8'd16);
        push_bus(32'h6000, 4'b0010, 32'h0000_3C00, 32'h0, 8'd0, 1'b1, 1'b1, 8'd0, 8'd17);
        push_resp(2'd0, 32'h0, 1'b0, 8'd17);
        issue(1'b0, 1'b1, 1'b0, 4'b0001, 32'h0000_6001, 32'h0000_003C, 1'b1, 8'd17);
        wait_quiet(8'd17);

        repeat (4) step();
        chk("scoreboard_empty", 128'(sbq.size()), 128'(0));
        chk("bus_queue_empty", 128'(bq.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
